msi_cache_controller: RTL
=========================

Name: msi_cache_controller

Overview:
- Per-block MSI coherence controller that sits directly upstream of one cache_block instance and is the only agent driving its write/state/address/data_in inputs.
- Serves CPU read/write requests against that block and issues bus transactions on misses: BusRd, BusRdX, or a writeback of a Modified victim.
- Snoops other caches' bus transactions and downgrades or invalidates the block, flushing dirty data when required.
- One controller plus one cache_block form one processor's cache node in the multi-core coherence system.

Parameters:
- ADDR_W, 3, block address width (matches cache_block address)
- DATA_W, 4, block data width (matches cache_block data)

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- cpu_valid  in  1  CPU request present; held until cpu_ready
- cpu_write  in  1  1=write, 0=read
- cpu_address  in  ADDR_W  request address
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  one-cycle pulse: request complete
- cpu_rdata  out  DATA_W  read data, valid with cpu_ready
- blk_state  in  2  cache_block current_state
- blk_address  in  ADDR_W  cache_block current_address
- blk_data  in  DATA_W  cache_block current_data
- blk_write  out  1  cache_block write strobe
- blk_next_state  out  2  cache_block state input
- blk_next_address  out  ADDR_W  cache_block address input
- blk_next_data  out  DATA_W  cache_block data_in
- bus_req  out  1  bus request, held until bus_done
- bus_gnt  in  1  bus grant from arbiter
- bus_op  out  2  00 NONE, 01 BUSRD, 10 BUSRDX, 11 WRITEBACK
- bus_address  out  ADDR_W  transaction address
- bus_wdata  out  DATA_W  writeback data
- bus_rdata  in  DATA_W  fill data, valid with bus_done
- bus_done  in  1  one-cycle transaction completion
- snoop_valid  in  1  another node's transaction on the bus; only asserted while bus_gnt=0
- snoop_op  in  2  same encoding as bus_op
- snoop_address  in  ADDR_W  snooped address
- snoop_flush  out  1  this node supplies dirty data this cycle
- snoop_data  out  DATA_W  flushed data

Behaviour:
- State encoding: 00 INVALID, 01 SHARED, 10 MODIFIED; 11 is illegal and treated as INVALID.
- Reset (async, resetn=0):
  - FSM to IDLE.
  - cpu_ready, blk_write, bus_req, snoop_flush = 0; bus_op = NONE.
  - All data/address outputs = 0.
  - blk_write is never asserted during reset.
  - Reset mid-transaction abandons the transaction and drops bus_req immediately.
- FSM states: IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP.
- IDLE with cpu_valid, hit = (blk_state != INVALID and blk_address == cpu_address):
  - Read hit → RESP; cpu_rdata = blk_data.
  - Write hit in MODIFIED → blk_write=1, blk_next_data=cpu_wdata, state stays MODIFIED → RESP.
  - Write hit in SHARED → FILL_REQ with bus_op=BUSRDX (upgrade).
  - Miss, victim MODIFIED → WB_REQ.
  - Miss, victim not MODIFIED → FILL_REQ (BUSRD for read, BUSRDX for write).
- WB_REQ:
  - bus_req=1, bus_op=WRITEBACK, bus_address=blk_address, bus_wdata=blk_data.
  - On bus_gnt → WB_WAIT.
- WB_WAIT: on bus_done → FILL_REQ.
- FILL_REQ: bus_req=1, bus_address=cpu_address; on bus_gnt → FILL_WAIT.
- FILL_WAIT: on bus_done:
  - blk_write=1, blk_next_address=cpu_address.
  - Read: blk_next_state=SHARED, blk_next_data=bus_rdata.
  - Write: blk_next_state=MODIFIED, blk_next_data=cpu_wdata.
  - Then → RESP.
- RESP:
  - cpu_ready=1 for exactly one cycle → IDLE.
  - cpu_rdata is the fill data or hit data.
- Latency:
  - Hit: 1 cycle from IDLE acceptance to cpu_ready.
  - Miss: arbiter latency + memory latency + 2 cycles.
- Snoop, combinational response, processed in any state where bus_gnt=0, only when blk_state != INVALID and blk_address == snoop_address:
  - BUSRD on MODIFIED → snoop_flush=1, snoop_data=blk_data; blk_write=1 with state SHARED.
  - BUSRD on SHARED → no action.
  - BUSRDX on MODIFIED → flush as above; state INVALID.
  - BUSRDX on SHARED → state INVALID, no flush.
  - WRITEBACK or NONE → ignored.
- Simultaneous snoop and CPU acceptance in IDLE:
  - The snoop update wins blk_write that cycle.
  - CPU request is not accepted; it is re-evaluated next cycle against the updated block.
- Snoop in WB_REQ/FILL_REQ:
  - Snoop updates the block; FSM stays put.
  - In WB_REQ, if the snoop invalidates or downgrades the victim, the FSM moves to FILL_REQ instead (no stale writeback).
- The WRITEBACK→fill sequence keeps bus_req low for one cycle between the two transactions (re-arbitration).
- Outputs not listed for a state default to 0 / NONE.

Decomposition:
- Shared package coherence_pkg:
  - State constants ST_INVALID, ST_SHARED, ST_MODIFIED.
  - Bus op constants OP_NONE, OP_BUSRD, OP_BUSRDX, OP_WRITEBACK.
  - FSM state typedef.
- One natural sub-module: msi_snoop_logic (combinational snoop match → flush/next state), reused by any future multi-block cache.

Test Plan:
- Reset with block INVALID; CPU read addr 3 → BUSRD addr 3; bus_rdata=4'hA → block {SHARED,3,A}, cpu_ready with cpu_rdata=A.
- Block {SHARED,3,A}; CPU read addr 3 → cpu_ready exactly 1 cycle after acceptance, cpu_rdata=A, no bus_req.
- Block {SHARED,3,A}; CPU write addr 3 data 5 → BUSRDX addr 3 → block {MODIFIED,3,5}.
- Block {MODIFIED,3,5}; CPU read addr 6 → WRITEBACK addr 3 data 5, then BUSRD addr 6 → block {SHARED,6,fill}.
- Block {MODIFIED,3,5}; snoop BUSRD addr 3 → snoop_flush=1, snoop_data=5, block SHARED; then snoop BUSRDX addr 3 → block INVALID, no flush.
- Snoop BUSRDX and CPU write to the same address in one IDLE cycle → invalidate first, then CPU miss path; resetn pulled low during FILL_WAIT → bus_req=0 immediately, FSM IDLE.

Source files
------------

// File: rtl/coherence_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : coherence_pkg
//  Purpose  : MSI block-state / bus-op encodings and controller FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package coherence_pkg;

    localparam logic [1:0] ST_INVALID  = 2'b00;
    localparam logic [1:0] ST_SHARED   = 2'b01;
    localparam logic [1:0] ST_MODIFIED = 2'b10;

    localparam logic [1:0] OP_NONE      = 2'b00;
    localparam logic [1:0] OP_BUSRD     = 2'b01;
    localparam logic [1:0] OP_BUSRDX    = 2'b10;
    localparam logic [1:0] OP_WRITEBACK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WB_REQ    = 3'd1,
        S_WB_WAIT   = 3'd2,
        S_FILL_REQ  = 3'd3,
        S_FILL_WAIT = 3'd4,
        S_RESP      = 3'd5
    } fsm_state_t;

    // Encoding 11 is illegal and behaves exactly like INVALID.
    function automatic logic is_valid_state(input logic [1:0] st);
        return (st == ST_SHARED) || (st == ST_MODIFIED);
    endfunction

endpackage
`default_nettype wire

// File: rtl/msi_cache_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : msi_cache_controller_if
//  Purpose  : CPU, cache-block, bus and snoop signals of one cache node.
//  Revision : 1.0 - initial release
// ============================================================================
interface msi_cache_controller_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
);
    logic              cpu_valid;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;

    logic [1:0]        blk_state;
    logic [ADDR_W-1:0] blk_address;
    logic [DATA_W-1:0] blk_data;
    logic              blk_write;
    logic [1:0]        blk_next_state;
    logic [ADDR_W-1:0] blk_next_address;
    logic [DATA_W-1:0] blk_next_data;

    logic              bus_req;
    logic              bus_gnt;
    logic [1:0]        bus_op;
    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_done;

    logic              snoop_valid;
    logic [1:0]        snoop_op;
    logic [ADDR_W-1:0] snoop_address;
    logic              snoop_flush;
    logic [DATA_W-1:0] snoop_data;

    modport master (
        input  cpu_valid, cpu_write, cpu_address, cpu_wdata,
        input  blk_state, blk_address, blk_data,
        input  bus_gnt, bus_rdata, bus_done,
        input  snoop_valid, snoop_op, snoop_address,
        output cpu_ready, cpu_rdata,
        output blk_write, blk_next_state, blk_next_address, blk_next_data,
        output bus_req, bus_op, bus_address, bus_wdata,
        output snoop_flush, snoop_data
    );

    modport slave (
        output cpu_valid, cpu_write, cpu_address, cpu_wdata,
        output blk_state, blk_address, blk_data,
        output bus_gnt, bus_rdata, bus_done,
        output snoop_valid, snoop_op, snoop_address,
        input  cpu_ready, cpu_rdata,
        input  blk_write, blk_next_state, blk_next_address, blk_next_data,
        input  bus_req, bus_op, bus_address, bus_wdata,
        input  snoop_flush, snoop_data
    );

endinterface
`default_nettype wire

// File: rtl/msi_snoop_logic.sv
`default_nettype none
// ============================================================================
//  Module   : msi_snoop_logic
//  Purpose  : Combinational snoop match -> flush and downgraded block state.
//  Revision : 1.0 - initial release
// ============================================================================
module msi_snoop_logic
    import coherence_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  wire logic              i_snoop_en,
    input  wire logic [1:0]        i_snoop_op,
    input  wire logic [ADDR_W-1:0] i_snoop_address,
    input  wire logic [1:0]        i_blk_state,
    input  wire logic [ADDR_W-1:0] i_blk_address,
    input  wire logic [DATA_W-1:0] i_blk_data,
    output logic                   o_flush,
    output logic [DATA_W-1:0]      o_flush_data,
    output logic                   o_upd_write,
    output logic [1:0]             o_upd_state
);

    logic w_match;
    logic w_dirty;

    assign w_match = i_snoop_en && is_valid_state(i_blk_state)
                     && (i_blk_address == i_snoop_address);
    assign w_dirty = (i_blk_state == ST_MODIFIED);

    always_comb begin
        o_flush      = 1'b0;
        o_flush_data = '0;
        o_upd_write  = 1'b0;
        o_upd_state  = ST_INVALID;
        if (w_match) begin
            case (i_snoop_op)
                OP_BUSRD: begin
                    if (w_dirty) begin
                        o_flush      = 1'b1;
                        o_flush_data = i_blk_data;
                        o_upd_write  = 1'b1;
                        o_upd_state  = ST_SHARED;
                    end
                end
                OP_BUSRDX: begin
                    o_flush      = w_dirty;
                    o_flush_data = w_dirty ? i_blk_data : '0;
                    o_upd_write  = 1'b1;
                    o_upd_state  = ST_INVALID;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/msi_cache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : msi_cache_controller
//  Purpose  : Per-block MSI controller: CPU hits/misses, bus fills, snoops.
//  Revision : 1.0 - initial release
// ============================================================================
module msi_cache_controller
    import coherence_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  wire logic               clock,
    input  wire logic               resetn,
    msi_cache_controller_if.master  cif
);

    fsm_state_t        r_state;
    logic              r_cpu_ready;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_bus_req;
    logic [1:0]        r_bus_op;
    logic [ADDR_W-1:0] r_bus_address;
    logic [DATA_W-1:0] r_bus_wdata;

    logic              w_snp_en;
    logic              w_snp_flush;
    logic [DATA_W-1:0] w_snp_data;
    logic              w_snp_write;
    logic [1:0]        w_snp_state;
    logic              w_hit;
    logic              w_accept;
    logic              w_fill_write;
    logic              w_hit_write;
    logic [1:0]        w_fill_op;
    logic              w_blk_write;
    logic [1:0]        w_blk_next_state;
    logic [ADDR_W-1:0] w_blk_next_address;
    logic [DATA_W-1:0] w_blk_next_data;

    // Snoops are only meaningful while another node owns the bus.
    assign w_snp_en = resetn && cif.snoop_valid && !cif.bus_gnt;

    msi_snoop_logic #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_snoop (
        .i_snoop_en      (w_snp_en),
        .i_snoop_op      (cif.snoop_op),
        .i_snoop_address (cif.snoop_address),
        .i_blk_state     (cif.blk_state),
        .i_blk_address   (cif.blk_address),
        .i_blk_data      (cif.blk_data),
        .o_flush         (w_snp_flush),
        .o_flush_data    (w_snp_data),
        .o_upd_write     (w_snp_write),
        .o_upd_state     (w_snp_state)
    );

    assign w_hit        = is_valid_state(cif.blk_state) && (cif.blk_address == cif.cpu_address);
    assign w_accept     = (r_state == S_IDLE) && cif.cpu_valid && !w_snp_write;
    assign w_fill_write = resetn && (r_state == S_FILL_WAIT) && cif.bus_done;
    assign w_hit_write  = resetn && w_accept && cif.cpu_write && w_hit
                          && (cif.blk_state == ST_MODIFIED);
    assign w_fill_op    = cif.cpu_write ? OP_BUSRDX : OP_BUSRD;

    // The fill owns the bus, so it cannot coincide with a live snoop.
    always_comb begin
        w_blk_write        = 1'b0;
        w_blk_next_state   = ST_INVALID;
        w_blk_next_address = '0;
        w_blk_next_data    = '0;
        if (w_fill_write) begin
            w_blk_write        = 1'b1;
            w_blk_next_state   = cif.cpu_write ? ST_MODIFIED : ST_SHARED;
            w_blk_next_address = cif.cpu_address;
            w_blk_next_data    = cif.cpu_write ? cif.cpu_wdata : cif.bus_rdata;
        end else if (w_snp_write) begin
            w_blk_write        = 1'b1;
            w_blk_next_state   = w_snp_state;
            w_blk_next_address = cif.blk_address;
            w_blk_next_data    = cif.blk_data;
        end else if (w_hit_write) begin
            w_blk_write        = 1'b1;
            w_blk_next_state   = ST_MODIFIED;
            w_blk_next_address = cif.cpu_address;
            w_blk_next_data    = cif.cpu_wdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_cpu_ready   <= 1'b0;
            r_cpu_rdata   <= '0;
            r_bus_req     <= 1'b0;
            r_bus_op      <= OP_NONE;
            r_bus_address <= '0;
            r_bus_wdata   <= '0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_hit && (!cif.cpu_write || cif.blk_state == ST_MODIFIED)) begin
                            r_state     <= S_RESP;
                            r_cpu_ready <= 1'b1;
                            r_cpu_rdata <= cif.cpu_write ? cif.cpu_wdata : cif.blk_data;
                        end else if (!w_hit && cif.blk_state == ST_MODIFIED) begin
                            r_state       <= S_WB_REQ;
                            r_bus_req     <= 1'b1;
                            r_bus_op      <= OP_WRITEBACK;
                            r_bus_address <= cif.blk_address;
                            r_bus_wdata   <= cif.blk_data;
                        end else begin
                            r_state       <= S_FILL_REQ;
                            r_bus_req     <= 1'b1;
                            r_bus_op      <= w_fill_op;
                            r_bus_address <= cif.cpu_address;
                            r_bus_wdata   <= '0;
                        end
                    end
                end
                S_WB_REQ: begin
                    // A snoop that downgrades the victim makes the writeback stale.
                    if (w_snp_write) begin
                        r_state       <= S_FILL_REQ;
                        r_bus_req     <= 1'b0;
                        r_bus_op      <= OP_NONE;
                        r_bus_address <= '0;
                        r_bus_wdata   <= '0;
                    end else if (cif.bus_gnt) begin
                        r_state <= S_WB_WAIT;
                    end
                end
                S_WB_WAIT: begin
                    if (cif.bus_done) begin
                        r_state       <= S_FILL_REQ;
                        r_bus_req     <= 1'b0;
                        r_bus_op      <= OP_NONE;
                        r_bus_address <= '0;
                        r_bus_wdata   <= '0;
                    end
                end
                S_FILL_REQ: begin
                    // Entered with bus_req low after a writeback: re-arbitrate first.
                    if (!r_bus_req) begin
                        r_bus_req     <= 1'b1;
                        r_bus_op      <= w_fill_op;
                        r_bus_address <= cif.cpu_address;
                        r_bus_wdata   <= '0;
                    end else if (cif.bus_gnt) begin
                        r_state <= S_FILL_WAIT;
                    end
                end
                S_FILL_WAIT: begin
                    if (cif.bus_done) begin
                        r_state       <= S_RESP;
                        r_cpu_ready   <= 1'b1;
                        r_cpu_rdata   <= cif.cpu_write ? cif.cpu_wdata : cif.bus_rdata;
                        r_bus_req     <= 1'b0;
                        r_bus_op      <= OP_NONE;
                        r_bus_address <= '0;
                        r_bus_wdata   <= '0;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cif.cpu_ready        = r_cpu_ready;
    assign cif.cpu_rdata        = r_cpu_rdata;
    assign cif.bus_req          = r_bus_req;
    assign cif.bus_op           = r_bus_op;
    assign cif.bus_address      = r_bus_address;
    assign cif.bus_wdata        = r_bus_wdata;
    assign cif.blk_write        = w_blk_write;
    assign cif.blk_next_state   = w_blk_next_state;
    assign cif.blk_next_address = w_blk_next_address;
    assign cif.blk_next_data    = w_blk_next_data;
    assign cif.snoop_flush      = w_snp_flush;
    assign cif.snoop_data       = w_snp_data;

endmodule
`default_nettype wire
